// File: rtl/opp_seq_ctrl.sv
// Opposite-matrix sequencer: reads ROWS 40-bit rows, negates each int8 lane, writes them back.
// Optional build macro OPP_SAT_EN saturates a -128 lane to +127 instead of wrapping.
module opp_seq_ctrl #(
  parameter int unsigned ROWS   = 5,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [39:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [39:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned LANES  = 5;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned ROW_W  = LANES * LANE_W;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ROW_W-1:0]    buf_q, buf_d;
  logic                ovf_d;
  logic                rd_en_d, wr_en_d, busy_d, done_d;
  logic [ADDR_W-1:0]   rd_addr_d, wr_addr_d;
  logic [ROW_W-1:0]    wr_data_d;

  // Per-lane two's-complement negation; lanes never carry into each other.
  function automatic logic [ROW_W-1:0] neg_row(input logic [ROW_W-1:0] x);
    logic [ROW_W-1:0]  r;
    logic [LANE_W-1:0] lane;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = x[i*LANE_W +: LANE_W];
`ifdef OPP_SAT_EN
      if (lane == 8'h80) r[i*LANE_W +: LANE_W] = 8'h7F;
      else               r[i*LANE_W +: LANE_W] = (~lane) + 8'd1;
`else
      r[i*LANE_W +: LANE_W] = (~lane) + 8'd1;
`endif
    end
    return r;
  endfunction

  function automatic logic has_min(input logic [ROW_W-1:0] x);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (x[i*LANE_W +: LANE_W] == 8'h80) hit = 1'b1;
    end
    return hit;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      ovf     <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      ovf     <= ovf_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state, then outputs decoded from the next state so registered strobes line up with it.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    src_d     = src_q;
    dst_d     = dst_q;
    buf_d     = buf_q;
    ovf_d     = ovf;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          row_d   = '0;
          ovf_d   = 1'b0;
          state_d = READ;
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        buf_d   = rd_data;
        state_d = WRITE;
      end
      WRITE: begin
        if (has_min(buf_q)) ovf_d = 1'b1;
        if (row_q == CNT_W'(ROWS - 1)) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + CNT_W'(1);
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == READ) begin
      rd_en_d   = 1'b1;
      rd_addr_d = src_d + ADDR_W'(row_d);
    end
    if (state_d == WRITE) begin
      wr_en_d   = 1'b1;
      wr_addr_d = dst_d + ADDR_W'(row_d);
      wr_data_d = neg_row(buf_d);
    end
    busy_d = (state_d == READ) || (state_d == WAIT) || (state_d == WRITE);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_opp_seq_ctrl.sv
// Scoreboard bench for opp_seq_ctrl: integer-arithmetic reference model, queue-based monitor.
module tb_opp_seq_ctrl;
  localparam int ROWS = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  src_base = '0, dst_base = '0;
  logic        rd_en, wr_en, busy, done, ovf;
  logic [7:0]  rd_addr, wr_addr;
  logic [39:0] rd_data = '0;
  logic [39:0] wr_data;

  opp_seq_ctrl #(.ROWS(ROWS), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] addr; logic [39:0] data; } acc_t;
  typedef struct { int cyc; logic ovf; } done_t;

  logic [39:0] mem [256];
  logic [39:0] ref_mem [256];
  acc_t  rq[$];
  acc_t  wq[$];
  done_t dq[$];
  int cyc = 0;
  int busy_lo = 1, busy_hi = 0;
  bit armed = 1'b0;
  int vectors = 0, miscompares = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference negation: lane as signed integer, arithmetic minus.
  function automatic logic [39:0] ref_neg(input logic [39:0] row);
    logic [39:0] r;
    logic [7:0]  b;
    int v, n;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      b = row[8*i +: 8];
      v = int'($signed(b));
      n = -v;
`ifdef OPP_SAT_EN
      if (v == -128) n = 127;
`endif
      r[8*i +: 8] = 8'(n);
    end
    return r;
  endfunction

  function automatic bit ref_has_min(input logic [39:0] row);
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      b = row[8*i +: 8];
      if (int'($signed(b)) == -128) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [39:0] rand_row();
    logic [39:0] r;
    for (int i = 0; i < 5; i++)
      r[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
    return r;
  endfunction

  // Monitor: pops expectations whenever the DUT strobes, flags stale or unexpected activity.
  always @(negedge clk) begin
    if (armed) begin
      acc_t  a;
      done_t d;
      bit    exp_busy;
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("rd_wr_overlap", 64'(rd_en & wr_en), 64'd0);
      while (rq.size() > 0 && rq[0].cyc < cyc) begin a = rq.pop_front(); chk("rd_missed", 64'(a.cyc), 64'(cyc)); end
      while (wq.size() > 0 && wq[0].cyc < cyc) begin a = wq.pop_front(); chk("wr_missed", 64'(a.cyc), 64'(cyc)); end
      while (dq.size() > 0 && dq[0].cyc < cyc) begin d = dq.pop_front(); chk("done_missed", 64'(d.cyc), 64'(cyc)); end
      if (rd_en) begin
        if (rq.size() == 0) chk("rd_unexpected", 64'(rd_addr), 64'hDEAD);
        else begin
          a = rq.pop_front();
          chk("rd_cycle", 64'(cyc), 64'(a.cyc));
          chk("rd_addr", 64'(rd_addr), 64'(a.addr));
        end
      end
      if (wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", 64'(wr_addr), 64'hDEAD);
        else begin
          a = wq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(a.cyc));
          chk("wr_addr", 64'(wr_addr), 64'(a.addr));
          chk("wr_data", 64'(wr_data), 64'(a.data));
        end
      end else begin
        chk("wr_data_idle", 64'(wr_data), 64'd0);
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else begin
          d = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("done_ovf", 64'(ovf), 64'(d.ovf));
        end
      end else if (!exp_busy) begin
        chk("idle_addrs", {48'd0, rd_addr, wr_addr}, 64'd0);
      end
    end
  end

  // One operation; abort_at>0 asserts rst at that relative cycle. noise pulses start at 2, 5, 16.
  task automatic run_op(input logic [7:0] s, input logic [7:0] d, input int abort_at, input bit noise);
    int t0, last, rcyc, wcyc;
    bit eovf, eovf_abort;
    logic [39:0] row, res;
    @(negedge clk);
    start = 1'b1; src_base = s; dst_base = d;
    t0 = cyc;
    eovf = 1'b0; eovf_abort = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      rcyc = t0 + 3*r + 1;
      wcyc = t0 + 3*r + 3;
      row = ref_mem[8'(s + 8'(r))];
      res = ref_neg(row);
      if (abort_at == 0 || rcyc <= t0 + abort_at) rq.push_back('{rcyc, 8'(s + 8'(r)), 40'd0});
      if (abort_at == 0 || wcyc <= t0 + abort_at) begin
        wq.push_back('{wcyc, 8'(d + 8'(r)), res});
        ref_mem[8'(d + 8'(r))] = res;
        if (ref_has_min(row)) begin
          eovf = 1'b1;
          if (wcyc + 1 <= t0 + abort_at) eovf_abort = 1'b1;
        end
      end
    end
    if (abort_at == 0) dq.push_back('{t0 + 3*ROWS + 1, eovf});
    busy_lo = t0 + 1;
    busy_hi = (abort_at != 0) ? t0 + abort_at : t0 + 3*ROWS;
    last = (abort_at != 0) ? abort_at : 3*ROWS + 1;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      start = noise && (i == 2 || i == 5 || i == 16);
      src_base = 8'($urandom);
      dst_base = 8'($urandom);
      if (i == 1) chk("ovf_cleared_on_start", 64'(ovf), 64'd0);
    end
    if (abort_at != 0) begin
      chk("ovf_before_abort", 64'(ovf), 64'(eovf_abort));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_outputs", {51'd0, busy, done, rd_en, wr_en, ovf, rd_addr}, 64'd0);
      chk("abort_wr_addr", 64'(wr_addr), 64'd0);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a] = rand_row();
      ref_mem[a] = mem[a];
    end
    mem[0] = 40'h01_02_FF_00_7F;      ref_mem[0] = mem[0];
    mem[40] = 40'h80_01_80_7F_00;     ref_mem[40] = mem[40];
    mem[100] = 40'h80_00_00_00_00;    ref_mem[100] = mem[100];
    mem[101] = 40'h00_00_00_00_00;    ref_mem[101] = mem[101];
    for (int a = 110; a < 115; a++) begin
      mem[a] = 40'h11_22_33_44_55;    ref_mem[a] = mem[a];
    end

    repeat (3) @(negedge clk);
    chk("reset_outputs", {51'd0, busy, done, rd_en, wr_en, ovf, rd_addr}, 64'd0);
    chk("reset_wr", {16'd0, wr_addr, wr_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    armed = 1'b1;

    run_op(8'd0, 8'd16, 0, 1'b0);
    chk("dir_row0_neg", 64'(mem[16]), 64'h00_00_00_FF_FE_01_00_81);

    run_op(8'd40, 8'd60, 0, 1'b0);
`ifdef OPP_SAT_EN
    chk("dir_min_lane", 64'(mem[60]), 64'h00_00_00_7F_FF_7F_81_00);
`else
    chk("dir_min_lane", 64'(mem[60]), 64'h00_00_00_80_FF_80_81_00);
`endif

    run_op(8'hFE, 8'hFE, 0, 1'b0);
    run_op(8'd20, 8'd21, 0, 1'b1);
    run_op(8'd30, 8'd70, 0, 1'b0);

    run_op(8'd100, 8'd120, 7, 1'b0);
    repeat (4) @(negedge clk);
    run_op(8'd110, 8'd130, 0, 1'b0);
    chk("post_abort_ovf", 64'(ovf), 64'd0);

    for (int k = 0; k < 20; k++)
      run_op(8'($urandom), 8'($urandom), 0, bit'($urandom_range(0, 1)));

    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rd_queue_drained", 64'(rq.size()), 64'd0);
    chk("wr_queue_drained", 64'(wq.size()), 64'd0);
    chk("done_queue_drained", 64'(dq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end
endmodule
